adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand and result width in bits (legal 2..64).
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = wrap-around result, 1 = signed saturation on overflow.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named clk and rst_n.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1: operands valid this cycle.
REQ-007 The block SHALL have port a, input, DATA_WIDTH: first operand.
REQ-008 The block SHALL have port b, input, DATA_WIDTH: second operand.
REQ-009 The block SHALL have port sub, input, 1: 0 = a+b, 1 = a-b.
REQ-010 The block SHALL have port out_valid, output, 1: result registered from an accepted operation.
REQ-011 The block SHALL have port result, output, DATA_WIDTH: registered sum or difference.
REQ-012 The block SHALL have port carry, output, 1: unsigned carry (add) or borrow (sub); present only under ADDER_FLAGS_EN.
REQ-013 The block SHALL have port overflow, output, 1: signed two's-complement overflow; present only under ADDER_FLAGS_EN.

Function
REQ-014 On a rising clk edge with in_valid=1, the block SHALL register result = (a + b) or (a - b) per sub; latency SHALL be exactly 1 cycle.
REQ-015 out_valid SHALL equal in_valid delayed by one cycle; there SHALL be no backpressure, and back-to-back operations SHALL produce one result per cycle.
REQ-016 With in_valid=0, result, carry and overflow SHALL hold their previous values and out_valid SHALL be 0 the next cycle.
REQ-017 With SATURATE=0, result SHALL be the true result modulo 2^DATA_WIDTH.
REQ-018 With SATURATE=1 and signed overflow, result SHALL clamp to 2^(W-1)-1 on positive overflow and -2^(W-1) on negative overflow; otherwise it SHALL be as in REQ-017.
REQ-019 carry SHALL be the bit out of the MSB of a+b for add, and 1 iff a < b unsigned for sub.
REQ-020 overflow SHALL be 1 iff the operand signs are equal (add) or different (sub) and the wrapped result sign differs from a's sign; it SHALL be computed before saturation.
REQ-021 The sub input SHALL be sampled in the same cycle as a and b; a change on sub with in_valid=0 SHALL have no effect.

Reset
REQ-022 While rst_n=0, result SHALL be 0, out_valid 0, carry 0 and overflow 0, with immediate effect regardless of clk.
REQ-023 An operation accepted in the cycle rst_n is asserted SHALL be discarded; after rst_n deasserts, the first in_valid=1 edge SHALL produce a result on the following cycle.

Configuration
REQ-024 With macro ADDER_FLAGS_EN defined, the carry and overflow ports and their registers SHALL exist per REQ-019/020.
REQ-025 Without ADDER_FLAGS_EN, the carry and overflow ports SHALL be absent; result, out_valid and saturation behaviour SHALL be unchanged.

Verification
REQ-026 a=3, b=5, sub=0, in_valid=1 -> next cycle result=8, out_valid=1, carry=0, overflow=0.
REQ-027 a=0xFFFFFFFF, b=1, add -> result=0x00000000, carry=1, overflow=0.
REQ-028 a=0x7FFFFFFF, b=1, add: SATURATE=0 -> result=0x80000000, overflow=1; SATURATE=1 -> result=0x7FFFFFFF, overflow=1.
REQ-029 a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry=1, overflow=0; a=0x80000000, b=1, sub, SATURATE=1 -> result=0x80000000, overflow=1.
REQ-030 Issue 10+20, then hold in_valid=0 for 3 cycles -> result stays 30 and out_valid=0 after the first cycle; rst_n pulse low mid-hold -> result=0 immediately.
REQ-031 Build without ADDER_FLAGS_EN and repeat REQ-026..028 -> identical result/out_valid values; no carry or overflow ports exist.

Source files
------------

// File: rtl/adder.sv
// Registered add/subtract with optional signed saturation.
// Optional carry/overflow flag ports are built when ADDER_FLAGS_EN is defined.
module adder #(
  parameter int DATA_WIDTH = 32,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
`ifdef ADDER_FLAGS_EN
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow
`else
  output logic [DATA_WIDTH-1:0] result
`endif
);

  localparam int W = DATA_WIDTH;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] b_op;
  logic [W:0]   sum_ext;
  logic [W-1:0] wrapped;
  logic         ovf;
  logic [W-1:0] res_next;

  // Subtract as a + ~b + 1 so one adder serves both operations.
  always_comb begin
    b_op     = sub ? ~b : b;
    sum_ext  = {1'b0, a} + {1'b0, b_op} + {{W{1'b0}}, sub};
    wrapped  = sum_ext[W-1:0];
    ovf      = ((a[W-1] ^ b_op[W-1]) == 1'b0)
             && (wrapped[W-1] != a[W-1]);
    res_next = wrapped;
    if (SATURATE && ovf) begin
      res_next = a[W-1] ? MAX_NEG : MAX_POS;
    end
  end

  // Result register holds its value when no operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (in_valid) begin
      result <= res_next;
    end
  end

  // Valid is the input valid delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

`ifdef ADDER_FLAGS_EN
  logic carry_next;

  // Carry-out of a+~b+1 is "no borrow", so invert it for subtract.
  always_comb begin
    carry_next = sub ? ~sum_ext[W] : sum_ext[W];
  end

  // Flag registers follow the result register's hold behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      carry    <= carry_next;
      overflow <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: wrap and saturating instances
// side by side, directed vectors then randomized traffic.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ov0, ov1;
  logic [31:0] r0, r1;
`ifdef ADDER_FLAGS_EN
  logic        c0, c1, f0, f1;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] e_r0 = '0;
  logic [31:0] e_r1 = '0;
  logic        e_v = 1'b0;
  logic        e_c = 1'b0;
  logic        e_o = 1'b0;

  always #5 clk = ~clk;

  adder #(.DATA_WIDTH(32), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .sub(sub), .out_valid(ov0),
`ifdef ADDER_FLAGS_EN
    .result(r0), .carry(c0), .overflow(f0)
`else
    .result(r0)
`endif
  );

  adder #(.DATA_WIDTH(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .sub(sub), .out_valid(ov1),
`ifdef ADDER_FLAGS_EN
    .result(r1), .carry(c1), .overflow(f1)
`else
    .result(r1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on 64-bit integers.
  task automatic model(input logic v, input logic [31:0] aa,
                       input logic [31:0] bb, input logic s);
    longint sa, sb, t;
    longint unsigned ua, ub;
    logic ovf;
    e_v = v;
    if (v) begin
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      ua = 64'(aa);
      ub = 64'(bb);
      t = s ? (sa - sb) : (sa + sb);
      ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      e_r0 = t[31:0];
      e_r1 = !ovf ? t[31:0] : (t > 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
      e_o = ovf;
      e_c = s ? (ua < ub) : ((ua + ub) > 64'hFFFF_FFFF);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".vld0"}, 64'(ov0), 64'(e_v));
    chk({tag, ".vld1"}, 64'(ov1), 64'(e_v));
    chk({tag, ".res0"}, 64'(r0), 64'(e_r0));
    chk({tag, ".res1"}, 64'(r1), 64'(e_r1));
`ifdef ADDER_FLAGS_EN
    chk({tag, ".c0"}, 64'(c0), 64'(e_c));
    chk({tag, ".c1"}, 64'(c1), 64'(e_c));
    chk({tag, ".o0"}, 64'(f0), 64'(e_o));
    chk({tag, ".o1"}, 64'(f1), 64'(e_o));
`endif
  endtask

  task automatic op(input string tag, input logic v,
                    input logic [31:0] aa, input logic [31:0] bb,
                    input logic s);
    @(negedge clk);
    in_valid = v;
    a = aa;
    b = bb;
    sub = s;
    model(v, aa, bb, s);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c[0] = 32'h0;
    c[1] = 32'h1;
    c[2] = 32'h7FFF_FFFF;
    c[3] = 32'h8000_0000;
    c[4] = 32'hFFFF_FFFF;
    c[5] = 32'h8000_0001;
    if ($urandom_range(3) == 0) return c[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    #2;
    chk("rst.vld0", 64'(ov0), 64'd0);
    chk("rst.res0", 64'(r0), 64'd0);
    chk("rst.res1", 64'(r1), 64'd0);

    // Operation offered while in reset must be discarded.
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'd11;
    b = 32'd22;
    @(posedge clk);
    #1;
    chk("rstop.vld", 64'(ov0), 64'd0);
    chk("rstop.res", 64'(r0), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    op("r026", 1'b1, 32'd3, 32'd5, 1'b0);
    chk("r026.lit", 64'(r0), 64'd8);
    op("r027", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("r027.lit", 64'(r0), 64'd0);
    op("r028", 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    chk("r028.wrap", 64'(r0), 64'h8000_0000);
    chk("r028.sat", 64'(r1), 64'h7FFF_FFFF);
    op("r029a", 1'b1, 32'd5, 32'd7, 1'b1);
    chk("r029a.lit", 64'(r0), 64'hFFFF_FFFE);
    op("r029b", 1'b1, 32'h8000_0000, 32'd1, 1'b1);
    chk("r029b.sat", 64'(r1), 64'h8000_0000);
    chk("r029b.wrap", 64'(r0), 64'h7FFF_FFFF);

    op("r030", 1'b1, 32'd10, 32'd20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op("hold", 1'b0, $urandom, $urandom, 1'($urandom));
    end
    chk("hold.lit", 64'(r0), 64'd30);

    // Reset pulse mid-hold clears state without a clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.res0", 64'(r0), 64'd0);
    chk("arst.res1", 64'(r1), 64'd0);
    chk("arst.vld", 64'(ov0), 64'd0);
    e_r0 = '0;
    e_r1 = '0;
    e_c = 1'b0;
    e_o = 1'b0;
    e_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    op("first", 1'b1, 32'd100, 32'd1, 1'b1);
    chk("first.lit", 64'(r0), 64'd99);

    for (int i = 0; i < 400; i++) begin
      op("rnd", 1'($urandom_range(3) != 0), pick(), pick(),
         1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
